// File: rtl/proc_mem_responder.sv
// proc_mem_responder: word-array responder for the core's imem/dmem ports.
// Fetches and loads are answered combinationally, and stores are committed
// on the clock edge. After reset a loader port fills the array. The core is
// held idle (run=0) until the loader signals load_done.
// Optional build macro: MEM_ERR_TRAP_EN. When it is defined, misaligned or
// out-of-range accesses are trapped into a sticky err flag.
module proc_mem_responder #(
   parameter int          WORDS     = 256,
   parameter logic [31:0] ADDR_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_val,
   output logic        load_rdy,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        load_done,
   output logic        run,
   input  logic        imemreq_val,
   input  logic [31:0] imemreq_addr,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic [31:0] dmemresp_rdata,
   output logic [15:0] store_count,
   output logic        err
);
   localparam int          AW   = $clog2(WORDS);
   localparam logic [31:0] SPAN = 32'(4 * WORDS);

   typedef enum logic {S_LOAD, S_RUN} state_t;
   state_t state, state_nxt;

   logic [31:0] mem [WORDS];

   // Offsets from the mapped base. The word index is taken from bits above
   // the byte lane, so the index wraps modulo WORDS.
   logic [31:0]   i_off, d_off, l_off;
   logic [AW-1:0] i_idx, d_idx, l_idx;
   logic          i_bad, d_bad, l_bad;

   assign i_off = imemreq_addr - ADDR_BASE;
   assign d_off = dmemreq_addr - ADDR_BASE;
   assign l_off = load_addr    - ADDR_BASE;
   assign i_idx = i_off[AW+1:2];
   assign d_idx = d_off[AW+1:2];
   assign l_idx = l_off[AW+1:2];

`ifdef MEM_ERR_TRAP_EN
   // An address below the base wraps to a huge offset, so the range
   // compare catches it as well.
   assign i_bad = (i_off[1:0] != 2'b00) || (i_off >= SPAN);
   assign d_bad = (d_off[1:0] != 2'b00) || (d_off >= SPAN);
   assign l_bad = (l_off[1:0] != 2'b00) || (l_off >= SPAN);
`else
   assign i_bad = 1'b0;
   assign d_bad = 1'b0;
   assign l_bad = 1'b0;
`endif

   // Byte-lane and high offset bits are only consulted by the trap logic.
   logic unused;
   assign unused = &{1'b0, i_off, d_off, l_off, SPAN};

   logic in_run, beat_en, st_en, w_en, err_set;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_data;

   assign in_run  = (state == S_RUN);
   assign beat_en = !in_run && load_val && load_rdy && !l_bad;
   assign st_en   = in_run && dmemreq_val && dmemreq_type && !d_bad;
   // rst gating keeps a store that is held through a reset edge out of the array.
   assign w_en    = rst && (beat_en || st_en);
   assign w_idx   = in_run ? d_idx : l_idx;
   assign w_data  = in_run ? dmemreq_wdata : load_data;
   assign err_set = in_run && ((imemreq_val && i_bad) || (dmemreq_val && d_bad));

   // The read mux sits ahead of the write, so a same-index reader sees the old word.
   assign imemresp_data  = (in_run && imemreq_val && !i_bad) ? mem[i_idx] : 32'h0;
   assign dmemresp_rdata = (in_run && dmemreq_val && !dmemreq_type && !d_bad)
                           ? mem[d_idx] : 32'h0;

   // Single shared write port. Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_en) mem[w_idx] <= w_data;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_LOAD;
      else      state <= state_nxt;
   end

   // Next state and handshake outputs. A coincident beat is written on the
   // same edge that leaves LOAD.
   always_comb begin
      state_nxt = state;
      load_rdy  = 1'b0;
      run       = 1'b0;
      case (state)
         S_LOAD: begin
            load_rdy = 1'b1;
            if (load_done) state_nxt = S_RUN;
         end
         S_RUN:   run = 1'b1;
         default: state_nxt = S_LOAD;
      endcase
   end

   // Saturating store counter and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_count <= 16'h0;
         err         <= 1'b0;
      end else begin
         if (st_en && store_count != 16'hFFFF) store_count <= store_count + 16'h1;
         if (err_set) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder (WORDS=256, ADDR_BASE=0).
module tb_proc_mem_responder;
   logic        clk = 1'b0, rst = 1'b0;
   logic        load_val, load_done, imemreq_val, dmemreq_val, dmemreq_type;
   logic [31:0] load_addr, load_data, imemreq_addr, dmemreq_addr, dmemreq_wdata;
   logic        load_rdy, run, err;
   logic [31:0] imemresp_data, dmemresp_rdata;
   logic [15:0] store_count;

   int          total = 0, bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   proc_mem_responder #(.WORDS(256), .ADDR_BASE(32'h0)) dut (
      .clk(clk), .rst(rst), .load_val(load_val), .load_rdy(load_rdy),
      .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .run(run), .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr),
      .imemresp_data(imemresp_data), .dmemreq_val(dmemreq_val),
      .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
      .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
      .store_count(store_count), .err(err));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic idle;
      load_val = 0; load_done = 0; load_addr = 0; load_data = 0;
      imemreq_val = 0; imemreq_addr = 0;
      dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
   endtask

   task automatic test_reset;
      idle(); rst = 0;
      imemreq_val = 1; imemreq_addr = 32'h0;
      repeat (2) tick();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      exp_q.push_back(0); exp_q.push_back(0);
      e = exp_q.pop_front(); total++;
      if ({31'b0, run} !== e) begin bad++; $display("FAIL reset_run got=%h exp=%h", run, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, load_rdy} !== e) begin bad++; $display("FAIL reset_rdy got=%h exp=%h", load_rdy, e); end
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL reset_cnt got=%h exp=%h", store_count, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, err} !== e) begin bad++; $display("FAIL reset_err got=%h exp=%h", err, e); end
      e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL reset_fetch got=%h exp=%h", imemresp_data, e); end
      idle(); rst = 1; tick();
   endtask

   task automatic test_load;
      logic [31:0] addrs [4];
      logic [31:0] datas [4];
      addrs = '{32'h0, 32'h4, 32'h100, 32'h200};
      datas = '{32'h00000513, 32'h00150513, 32'h0, 32'h0};
      for (int i = 0; i < 4; i++) begin
         load_val = 1; load_addr = addrs[i]; load_data = datas[i];
         tick();
      end
      load_val = 0;
      exp_q.push_back(0); #1; e = exp_q.pop_front(); total++;
      if ({31'b0, run} !== e) begin bad++; $display("FAIL load_run_before got=%h exp=%h", run, e); end
      load_done = 1; tick(); load_done = 0;
      exp_q.push_back(1); exp_q.push_back(0);
      e = exp_q.pop_front(); total++;
      if ({31'b0, run} !== e) begin bad++; $display("FAIL load_run_after got=%h exp=%h", run, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, load_rdy} !== e) begin bad++; $display("FAIL load_rdy_after got=%h exp=%h", load_rdy, e); end
      imemreq_val = 1; imemreq_addr = 32'h4;
      exp_q.push_back(32'h00150513); #1; e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL load_fetch4 got=%h exp=%h", imemresp_data, e); end
      idle(); tick();
   endtask

   task automatic test_store_raw;
      dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hdeadbeef;
      imemreq_val = 1; imemreq_addr = 32'h100;
      exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL raw_old got=%h exp=%h", imemresp_data, e); end
      tick();
      dmemreq_type = 0;
      exp_q.push_back(32'hdeadbeef); exp_q.push_back(32'hdeadbeef); exp_q.push_back(1);
      #1; e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL raw_new_load got=%h exp=%h", dmemresp_rdata, e); end
      e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL raw_new_fetch got=%h exp=%h", imemresp_data, e); end
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL raw_cnt got=%h exp=%h", store_count, e); end
      idle(); tick();
   endtask

   task automatic test_misaligned;
      dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h102; dmemreq_wdata = 32'ha5a5a5a5;
      tick();
      dmemreq_type = 0; dmemreq_addr = 32'h100;
`ifdef MEM_ERR_TRAP_EN
      exp_q.push_back(32'hdeadbeef); exp_q.push_back(1); exp_q.push_back(1);
`else
      exp_q.push_back(32'ha5a5a5a5); exp_q.push_back(2); exp_q.push_back(0);
`endif
      #1; e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL mis_word got=%h exp=%h", dmemresp_rdata, e); end
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL mis_cnt got=%h exp=%h", store_count, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, err} !== e) begin bad++; $display("FAIL mis_err got=%h exp=%h", err, e); end
      idle(); tick();
   endtask

   task automatic test_range;
      dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h400;
      imemreq_val = 1; imemreq_addr = 32'h404;
`ifdef MEM_ERR_TRAP_EN
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(1);
`else
      exp_q.push_back(32'h00000513); exp_q.push_back(32'h00150513); exp_q.push_back(0);
`endif
      #1; e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL range_load got=%h exp=%h", dmemresp_rdata, e); end
      e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL range_fetch got=%h exp=%h", imemresp_data, e); end
      tick(); idle();
      e = exp_q.pop_front(); total++;
      if ({31'b0, err} !== e) begin bad++; $display("FAIL range_err got=%h exp=%h", err, e); end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         dmemreq_val = 1; dmemreq_type = 1;
         dmemreq_addr = 32'h300 + 32'(4 * i); dmemreq_wdata = d;
         exp_q.push_back(d);
         tick();
      end
      dmemreq_type = 0;
      for (int i = 0; i < 8; i++) begin
         dmemreq_addr = 32'h300 + 32'(4 * i);
         #1; e = exp_q.pop_front(); total++;
         if (dmemresp_rdata !== e) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, dmemresp_rdata, e); end
         tick();
      end
`ifdef MEM_ERR_TRAP_EN
      exp_q.push_back(9);
`else
      exp_q.push_back(10);
`endif
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL b2b_cnt got=%h exp=%h", store_count, e); end
      idle(); tick();
   endtask

   task automatic test_coincident;
      rst = 0; #2; rst = 1;
      // A store while loading is ignored and not counted.
      dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h0; dmemreq_wdata = 32'hffffffff;
      imemreq_val = 1; imemreq_addr = 32'h0;
      exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL coin_fetch_in_load got=%h exp=%h", imemresp_data, e); end
      tick();
      dmemreq_type = 0; dmemreq_addr = 32'h4;
      exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL coin_load_in_load got=%h exp=%h", dmemresp_rdata, e); end
      idle();
      load_val = 1; load_addr = 32'h8; load_data = 32'h12345678; load_done = 1;
      tick(); idle();
      imemreq_val = 1; imemreq_addr = 32'h8;
      dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h0;
      exp_q.push_back(1); exp_q.push_back(32'h12345678); exp_q.push_back(32'h00000513); exp_q.push_back(0);
      #1; e = exp_q.pop_front(); total++;
      if ({31'b0, run} !== e) begin bad++; $display("FAIL coin_run got=%h exp=%h", run, e); end
      e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL coin_fetch8 got=%h exp=%h", imemresp_data, e); end
      e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL coin_word0 got=%h exp=%h", dmemresp_rdata, e); end
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL coin_cnt got=%h exp=%h", store_count, e); end
      idle(); tick();
   endtask

   task automatic test_async_reset;
      dmemreq_val = 1; dmemreq_type = 1; dmemreq_wdata = 32'h00000001; dmemreq_addr = 32'h10;
      tick();
      dmemreq_addr = 32'h0; dmemreq_wdata = 32'hcafef00d;
      #2; rst = 0; #1;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
      e = exp_q.pop_front(); total++;
      if ({31'b0, run} !== e) begin bad++; $display("FAIL arst_run got=%h exp=%h", run, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, load_rdy} !== e) begin bad++; $display("FAIL arst_rdy got=%h exp=%h", load_rdy, e); end
      e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL arst_cnt got=%h exp=%h", store_count, e); end
      e = exp_q.pop_front(); total++;
      if ({31'b0, err} !== e) begin bad++; $display("FAIL arst_err got=%h exp=%h", err, e); end
      tick(); rst = 1; idle();
      load_done = 1; tick(); load_done = 0;
      dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h0;
      imemreq_val = 1; imemreq_addr = 32'h8;
      exp_q.push_back(32'h00000513); exp_q.push_back(32'h12345678);
      #1; e = exp_q.pop_front(); total++;
      if (dmemresp_rdata !== e) begin bad++; $display("FAIL arst_word0 got=%h exp=%h", dmemresp_rdata, e); end
      e = exp_q.pop_front(); total++;
      if (imemresp_data !== e) begin bad++; $display("FAIL arst_word8 got=%h exp=%h", imemresp_data, e); end
      idle(); tick();
   endtask

   task automatic test_saturate;
      dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h200;
      for (int i = 0; i < 65534; i++) begin
         dmemreq_wdata = 32'(i);
         tick();
      end
      exp_q.push_back(32'hFFFE); e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL sat_fffe got=%h exp=%h", store_count, e); end
      repeat (4) tick();
      exp_q.push_back(32'hFFFF); e = exp_q.pop_front(); total++;
      if ({16'b0, store_count} !== e) begin bad++; $display("FAIL sat_ffff got=%h exp=%h", store_count, e); end
      idle(); tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_load();
      test_store_raw();
      test_misaligned();
      test_range();
      test_back_to_back();
      test_coincident();
      test_async_reset();
      test_saturate();
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
